// File: rtl/burst_cmd_ram.sv
// Command-driven single-port RAM: {opcode,payload} commands in, burst read beats out.
// Latency: first read beat is valid the cycle after READ is accepted; then one beat per cycle.
// Backpressure: tx_ready=0 freezes dout/tx_valid/pointers; rx_ready is low for a whole burst.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   rx_valid/rx_ready  command handshake; din = {opcode[1:0], payload[DATA_WIDTH-1:0]}
//   tx_valid/tx_ready  read-beat handshake; dout = read data
//   busy               burst in progress
//   addr_err           one-cycle pulse after a SET_WR/SET_RD with address >= MEM_DEPTH
module burst_cmd_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_SIZE  = 8,
    parameter int MEM_DEPTH  = 256,
    parameter int BURST_W    = 4,
    parameter int AUTO_INC   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic [DATA_WIDTH+1:0] din,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  busy,
    output logic                  addr_err
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [1:0] OP_SET_WR = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_SET_RD = 2'b10;
    localparam logic [1:0] OP_READ   = 2'b11;

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);
    // One extra bit so MEM_DEPTH == 2**ADDR_SIZE is representable.
    localparam logic [ADDR_SIZE:0]   DEPTH_EXT = (ADDR_SIZE + 1)'(MEM_DEPTH);

    // Wraps at MEM_DEPTH-1, not at 2**ADDR_SIZE, so non-power-of-two depths stay in range.
    function automatic logic [ADDR_SIZE-1:0] wrap_inc(input logic [ADDR_SIZE-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + ADDR_SIZE'(1);
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    state_t               state;
    logic [ADDR_SIZE-1:0] wr_ptr;
    logic [ADDR_SIZE-1:0] rd_ptr;
    // Beats still to load after the one currently in the output register.
    logic [BURST_W-1:0]   beats_left;

    logic [1:0]            opcode;
    logic [DATA_WIDTH-1:0] payload;
    logic [ADDR_SIZE-1:0]  cmd_addr;
    logic                  addr_ok;
    logic                  accept;
    logic                  out_free;
    logic [ADDR_SIZE-1:0]  wr_next;
    logic [ADDR_SIZE-1:0]  rd_next;

    assign opcode   = din[DATA_WIDTH+1:DATA_WIDTH];
    assign payload  = din[DATA_WIDTH-1:0];
    assign cmd_addr = payload[ADDR_SIZE-1:0];
    assign addr_ok  = ({1'b0, cmd_addr} < DEPTH_EXT);

    assign rx_ready = (state == IDLE) && !rst;
    assign accept   = rx_valid && rx_ready;
    assign busy     = (state == BURST);
    assign out_free = !tx_valid || tx_ready;

    assign wr_next = (AUTO_INC != 0) ? wrap_inc(wr_ptr) : wr_ptr;
    assign rd_next = (AUTO_INC != 0) ? wrap_inc(rd_ptr) : rd_ptr;

    // Storage has no reset: contents survive rst by design.
    always_ff @(posedge clk) begin
        if (accept && (opcode == OP_WRITE)) begin
            mem[wr_ptr] <= payload;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            beats_left <= '0;
            dout       <= '0;
            tx_valid   <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            addr_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (opcode)
                            OP_SET_WR: begin
                                if (addr_ok) wr_ptr <= cmd_addr;
                                else         addr_err <= 1'b1;
                            end
                            OP_WRITE: begin
                                wr_ptr <= wr_next;
                            end
                            OP_SET_RD: begin
                                if (addr_ok) rd_ptr <= cmd_addr;
                                else         addr_err <= 1'b1;
                            end
                            default: begin
                                // READ: the first beat is loaded on the accepting edge,
                                // which gives the one-cycle read latency.
                                dout       <= mem[rd_ptr];
                                tx_valid   <= 1'b1;
                                rd_ptr     <= rd_next;
                                beats_left <= payload[BURST_W-1:0];
                                state      <= BURST;
                            end
                        endcase
                    end
                end
                BURST: begin
                    if (out_free) begin
                        if (beats_left != '0) begin
                            dout       <= mem[rd_ptr];
                            tx_valid   <= 1'b1;
                            rd_ptr     <= rd_next;
                            beats_left <= beats_left - BURST_W'(1);
                        end else begin
                            // Last beat just handshaken: back to accepting commands.
                            tx_valid <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_burst_cmd_ram.sv
// Directed bench for burst_cmd_ram: three instances (default, MEM_DEPTH=200, AUTO_INC=0).
// Read beats are checked against a queue of expected words filled when READ is issued.
module tb_burst_cmd_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       rx_valid [3];
    logic       rx_ready [3];
    logic [9:0] din      [3];
    logic       tx_valid [3];
    logic       tx_ready [3];
    logic [7:0] dout     [3];
    logic       busy     [3];
    logic       addr_err [3];

    logic [7:0] expq [$];
    int n_assert = 0;
    int n_fail   = 0;

    burst_cmd_ram dut0 (
        .clk(clk), .rst(rst), .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]), .din(din[0]),
        .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .dout(dout[0]), .busy(busy[0]),
        .addr_err(addr_err[0])
    );

    burst_cmd_ram #(.MEM_DEPTH(200)) dut1 (
        .clk(clk), .rst(rst), .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]), .din(din[1]),
        .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .dout(dout[1]), .busy(busy[1]),
        .addr_err(addr_err[1])
    );

    burst_cmd_ram #(.AUTO_INC(0)) dut2 (
        .clk(clk), .rst(rst), .rx_valid(rx_valid[2]), .rx_ready(rx_ready[2]), .din(din[2]),
        .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]), .dout(dout[2]), .busy(busy[2]),
        .addr_err(addr_err[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic cmd(input int i, input logic [1:0] op, input logic [7:0] pl);
        int n = 0;
        rx_valid[i] = 1'b1;
        din[i]      = {op, pl};
        while (!rx_ready[i] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("cmd_accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        rx_valid[i] = 1'b0;
    endtask

    // Consume nb beats with tx_ready high, comparing against the queue.
    task automatic drain(input int i, input int nb, input string tag);
        int got = 0;
        int t   = 0;
        logic [7:0] e;
        tx_ready[i] = 1'b1;
        while (got < nb && t < 100) begin
            if (tx_valid[i]) begin
                if (expq.size() == 0) begin
                    chk({tag, "_unexpected_beat"}, 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    chk({tag, "_beat"}, {24'd0, dout[i]}, {24'd0, e});
                end
                got++;
            end
            @(negedge clk);
            t++;
        end
        tx_ready[i] = 1'b0;
        chk({tag, "_beats_seen"}, got, nb);
        // Starting with the first beat already valid, nb beats take exactly nb cycles.
        chk({tag, "_no_bubbles"}, t, nb);
    endtask

    task automatic post_burst(input int i, input string tag);
        chk({tag, "_tx_valid_low"}, {31'd0, tx_valid[i]}, 32'd0);
        chk({tag, "_busy_low"},     {31'd0, busy[i]},     32'd0);
        chk({tag, "_rx_ready_high"},{31'd0, rx_ready[i]}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rx_valid[i] = 1'b0;
            din[i]      = '0;
            tx_ready[i] = 1'b0;
        end

        // 1: reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_tx_valid", {31'd0, tx_valid[0]}, 32'd0);
        chk("rst_dout",     {24'd0, dout[0]},     32'd0);
        chk("rst_busy",     {31'd0, busy[0]},     32'd0);
        chk("rst_addr_err", {31'd0, addr_err[0]}, 32'd0);
        chk("rst_rx_ready", {31'd0, rx_ready[0]}, 32'd0);
        @(negedge clk);
        chk("rst_rx_ready2", {31'd0, rx_ready[0]}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rx_ready", {31'd0, rx_ready[0]}, 32'd1);
        chk("post_rst_busy",     {31'd0, busy[0]},     32'd0);

        // 2: two writes, burst of two with no backpressure
        cmd(0, 2'b00, 8'h10);
        cmd(0, 2'b01, 8'hAA);
        cmd(0, 2'b01, 8'hBB);
        cmd(0, 2'b10, 8'h10);
        expq.push_back(8'hAA);
        expq.push_back(8'hBB);
        cmd(0, 2'b11, 8'h01);
        chk("t2_busy_in_burst", {31'd0, busy[0]}, 32'd1);
        drain(0, 2, "t2");
        post_burst(0, "t2");

        // 3: same burst with three cycles of backpressure on the first beat
        cmd(0, 2'b10, 8'h10);
        expq.push_back(8'hAA);
        expq.push_back(8'hBB);
        cmd(0, 2'b11, 8'h01);
        for (int k = 0; k < 3; k++) begin
            chk("t3_hold_valid",   {31'd0, tx_valid[0]}, 32'd1);
            chk("t3_hold_dout",    {24'd0, dout[0]},     32'h0AA);
            chk("t3_hold_rx_rdy",  {31'd0, rx_ready[0]}, 32'd0);
            @(negedge clk);
        end
        drain(0, 2, "t3");
        post_burst(0, "t3");

        // 4: write pointer wraps from FF to 00, read pointer follows
        cmd(0, 2'b00, 8'hFF);
        cmd(0, 2'b01, 8'h11);
        cmd(0, 2'b01, 8'h22);
        cmd(0, 2'b10, 8'hFF);
        expq.push_back(8'h11);
        expq.push_back(8'h22);
        cmd(0, 2'b11, 8'h01);
        drain(0, 2, "t4");
        post_burst(0, "t4");
        cmd(0, 2'b10, 8'h00);
        expq.push_back(8'h22);
        cmd(0, 2'b11, 8'h00);
        drain(0, 1, "t4_mem0");

        // 5: MEM_DEPTH=200, out-of-range SET_WR/SET_RD and wrap at 199
        cmd(1, 2'b00, 8'h10);
        chk("t5_no_err_in_range", {31'd0, addr_err[1]}, 32'd0);
        cmd(1, 2'b00, 8'hC8);
        chk("t5_addr_err_pulse", {31'd0, addr_err[1]}, 32'd1);
        @(negedge clk);
        chk("t5_addr_err_clear", {31'd0, addr_err[1]}, 32'd0);
        cmd(1, 2'b01, 8'h55);
        cmd(1, 2'b10, 8'h10);
        cmd(1, 2'b10, 8'hC8);
        chk("t5_rd_addr_err", {31'd0, addr_err[1]}, 32'd1);
        expq.push_back(8'h55);
        cmd(1, 2'b11, 8'h00);
        drain(1, 1, "t5_kept_ptr");
        cmd(1, 2'b00, 8'hC7);
        cmd(1, 2'b01, 8'h66);
        cmd(1, 2'b01, 8'h77);
        cmd(1, 2'b10, 8'hC7);
        expq.push_back(8'h66);
        expq.push_back(8'h77);
        cmd(1, 2'b11, 8'h01);
        drain(1, 2, "t5_wrap199");
        post_burst(1, "t5");

        // 6: 16-beat burst interrupted by reset after five beats
        cmd(0, 2'b00, 8'h20);
        for (int k = 0; k < 16; k++) begin
            cmd(0, 2'b01, 8'h30 + k[7:0]);
        end
        cmd(0, 2'b10, 8'h20);
        for (int k = 0; k < 5; k++) begin
            expq.push_back(8'h30 + k[7:0]);
        end
        cmd(0, 2'b11, 8'h0F);
        begin
            int t = 0;
            int got = 0;
            tx_ready[0] = 1'b1;
            while (got < 5 && t < 100) begin
                if (tx_valid[0]) begin
                    chk("t6_beat", {24'd0, dout[0]}, {24'd0, expq.pop_front()});
                    got++;
                end
                @(negedge clk);
                t++;
            end
            tx_ready[0] = 1'b0;
            chk("t6_beats_before_rst", got, 5);
        end
        chk("t6_sixth_loaded", {24'd0, dout[0]}, 32'h035);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_tx_valid", {31'd0, tx_valid[0]}, 32'd0);
        chk("t6_rst_busy",     {31'd0, busy[0]},     32'd0);
        chk("t6_rst_dout",     {24'd0, dout[0]},     32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_no_stray_beat", {31'd0, tx_valid[0]}, 32'd0);
        cmd(0, 2'b10, 8'h25);
        expq.push_back(8'h35);
        cmd(0, 2'b11, 8'h00);
        drain(0, 1, "t6_after_rst");
        cmd(0, 2'b10, 8'h20);
        expq.push_back(8'h30);
        expq.push_back(8'h31);
        cmd(0, 2'b11, 8'h01);
        drain(0, 2, "t6_mem_kept");
        post_burst(0, "t6");

        // AUTO_INC=0: writes overwrite one address, reads repeat one word
        cmd(2, 2'b00, 8'h05);
        cmd(2, 2'b01, 8'hA1);
        cmd(2, 2'b01, 8'hB2);
        cmd(2, 2'b10, 8'h05);
        for (int k = 0; k < 3; k++) expq.push_back(8'hB2);
        cmd(2, 2'b11, 8'h02);
        drain(2, 3, "t7_noinc");
        post_burst(2, "t7");

        chk("queue_empty", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
